// File: rtl/shift_out_port_if.sv
// Signal bundle between a parallel byte writer and the serial display port.
// The writer (master) offers bytes; the port (slave) drives the serial side and status.
interface shift_out_port_if;
   logic       WR;
   logic [7:0] D;
   logic       SCLK;
   logic       SDATA;
   logic       LATCH;
   logic       FULL;
   logic       BUSY;
   logic       DROP;

   modport master (
      output WR, D,
      input  SCLK, SDATA, LATCH, FULL, BUSY, DROP
   );

   modport slave (
      input  WR, D,
      output SCLK, SDATA, LATCH, FULL, BUSY, DROP
   );
endinterface

// File: rtl/shift_out_port.sv
// Serialises bytes MSB first to a display shift register, strobes LATCH after each byte,
// and buffers one extra byte so back-to-back writes stream with no idle gap.
module shift_out_port #(
   parameter int DIV = 2
) (
   input  logic            CLK,
   input  logic            RST,
   shift_out_port_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] div_q, div_d;
   logic [7:0] hold_q, hold_d;
   logic       full_q, full_d;
   logic       sclk_q, sclk_d;
   logic       latch_q, latch_d;
   logic       busy_q, busy_d;
   logic       drop_q, drop_d;
   logic       phase_end;
   logic       last_latch;
   logic       load_en;
   logic [7:0] load_byte;

   assign phase_end  = (div_q == DIV_LAST);
   assign last_latch = (state_q == ST_LATCH) && phase_end;

   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      shift_d   = shift_q;
      bit_d     = bit_q;
      div_d     = div_q;
      hold_d    = hold_q;
      full_d    = full_q;
      sclk_d    = sclk_q;
      latch_d   = latch_q;
      drop_d    = 1'b0;
      load_en   = 1'b0;
      load_byte = bus.D;

      unique case (state_q)
         ST_IDLE: begin
            load_en = bus.WR;
         end
         ST_SHIFT: begin
            if (!phase_end) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d = 8'd0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Shifting after bit 0 too leaves zeros behind, so SDATA idles low in LATCH.
                  sclk_d  = 1'b0;
                  shift_d = {shift_q[6:0], 1'b0};
                  if (bit_q == 3'd7) begin
                     state_d = ST_LATCH;
                     latch_d = 1'b1;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
            end
         end
         ST_LATCH: begin
            if (!phase_end) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d   = 8'd0;
               latch_d = 1'b0;
               if (full_q) begin
                  // Held byte goes out next; a simultaneous write refills the holding slot.
                  load_en   = 1'b1;
                  load_byte = hold_q;
                  if (bus.WR) hold_d = bus.D;
                  else        full_d = 1'b0;
               end else if (bus.WR) begin
                  load_en = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_en) begin
         state_d = ST_SHIFT;
         shift_d = load_byte;
         bit_d   = 3'd0;
         div_d   = 8'd0;
         sclk_d  = 1'b0;
      end

      if (bus.WR && (state_q != ST_IDLE) && !last_latch) begin
         if (full_q) begin
            drop_d = 1'b1;
         end else begin
            hold_d = bus.D;
            full_d = 1'b1;
         end
      end

      busy_d = (state_d != ST_IDLE) || full_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         shift_q <= 8'd0;
         bit_q   <= 3'd0;
         div_q   <= 8'd0;
         hold_q  <= 8'd0;
         full_q  <= 1'b0;
         sclk_q  <= 1'b0;
         latch_q <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         hold_q  <= hold_d;
         full_q  <= full_d;
         sclk_q  <= sclk_d;
         latch_q <= latch_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.SCLK  = sclk_q;
   assign bus.SDATA = shift_q[7];
   assign bus.LATCH = latch_q;
   assign bus.FULL  = full_q;
   assign bus.BUSY  = busy_q;
   assign bus.DROP  = drop_q;
endmodule

// File: tb/tb_shift_out_port.sv
// Self-checking bench for shift_out_port: a timeline model of queued bytes is compared every
// cycle, plus directed vectors and the multi-cycle boundary sequences.
module tb_shift_out_port;
   localparam int DIV = 2;
   localparam int BYTE_CYCLES = 17 * DIV;

   logic CLK = 1'b0;
   logic RST;

   shift_out_port_if bus ();

   shift_out_port #(.DIV(DIV)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one byte in flight timed by elapsed cycles, plus a one-entry queue.
   bit         m_active;
   logic [7:0] m_cur;
   int         m_t;
   logic [7:0] m_q[$];
   bit         m_drop;
   int         m_drops_total;

   // Monitor state, derived from DUT outputs.
   logic       sclk_prev, latch_prev;
   logic [7:0] coll;
   int         rises, last_rise, cyc;
   int         busy_cycles, latch_cycles, full_cycles, drop_pulses;
   logic [7:0] dut_bytes[$];

   typedef struct {
      logic [7:0] d;
      logic [7:0] exp_bits;
      int         exp_busy;
      int         exp_latch;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_active = 1'b0;
      m_cur    = 8'd0;
      m_t      = 0;
      m_q.delete();
      m_drop   = 1'b0;
   endfunction

   function automatic void model_step(input logic wr, input logic [7:0] d);
      bit fin;
      fin    = m_active && (m_t == BYTE_CYCLES - 1);
      m_drop = 1'b0;
      if (!m_active) begin
         if (wr) begin
            m_active = 1'b1;
            m_cur    = d;
            m_t      = 0;
         end
      end else if (fin) begin
         if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_t   = 0;
            if (wr) m_q.push_back(d);
         end else if (wr) begin
            m_cur = d;
            m_t   = 0;
         end else begin
            m_active = 1'b0;
         end
      end else begin
         m_t++;
         if (wr) begin
            if (m_q.size() > 0) begin
               m_drop = 1'b1;
               m_drops_total++;
            end else begin
               m_q.push_back(d);
            end
         end
      end
   endfunction

   task automatic compare_all();
      logic e_sclk, e_sdata, e_latch;
      int   bit_i;
      e_sclk  = 1'b0;
      e_sdata = 1'b0;
      e_latch = 1'b0;
      if (m_active) begin
         if (m_t < 16 * DIV) begin
            bit_i   = m_t / (2 * DIV);
            e_sclk  = (m_t % (2 * DIV)) >= DIV;
            e_sdata = m_cur[7 - bit_i];
         end else begin
            e_latch = 1'b1;
         end
      end
      check("sclk",  bus.SCLK,  e_sclk);
      check("sdata", bus.SDATA, e_sdata);
      check("latch", bus.LATCH, e_latch);
      check("full",  bus.FULL,  m_q.size() != 0);
      check("busy",  bus.BUSY,  m_active || (m_q.size() != 0));
      check("drop",  bus.DROP,  m_drop);
   endtask

   function automatic void mon_clear();
      sclk_prev    = 1'b0;
      latch_prev   = 1'b0;
      coll         = 8'd0;
      rises        = 0;
      busy_cycles  = 0;
      latch_cycles = 0;
      full_cycles  = 0;
      drop_pulses  = 0;
      dut_bytes.delete();
   endfunction

   task automatic monitor();
      if (bus.BUSY)  busy_cycles++;
      if (bus.LATCH) latch_cycles++;
      if (bus.FULL)  full_cycles++;
      if (bus.DROP)  drop_pulses++;
      if (bus.SCLK && !sclk_prev) begin
         if (rises > 0) check("sclk_spacing", cyc - last_rise, 2 * DIV);
         rises++;
         last_rise = cyc;
         coll = {coll[6:0], bus.SDATA};
      end
      if (bus.LATCH && !latch_prev) begin
         check("rises_per_byte", rises, 8);
         dut_bytes.push_back(coll);
         rises = 0;
      end
      sclk_prev  = bus.SCLK;
      latch_prev = bus.LATCH;
      cyc++;
   endtask

   task automatic step(input logic wr, input logic [7:0] d);
      bus.WR = wr;
      bus.D  = d;
      @(posedge CLK);
      model_step(wr, d);
      @(negedge CLK);
      compare_all();
      monitor();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (bus.BUSY && n < budget) begin
         step(1'b0, 8'h00);
         n++;
      end
      if (bus.BUSY) check("drain_timeout", 1, 0);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic check_bytes(input string name, input logic [7:0] exp[$]);
      check({name, "_count"}, dut_bytes.size(), exp.size());
      for (int i = 0; i < exp.size() && i < dut_bytes.size(); i++)
         check({name, "_byte"}, dut_bytes[i], exp[i]);
   endtask

   initial begin
      cyc           = 0;
      last_rise     = 0;
      m_drops_total = 0;
      mon_clear();
      model_reset();

      vecs[0] = '{8'hA5, 8'b1010_0101, 34, 2};
      vecs[1] = '{8'hFF, 8'b1111_1111, 34, 2};
      vecs[2] = '{8'h00, 8'b0000_0000, 34, 2};
      vecs[3] = '{8'h3C, 8'b0011_1100, 34, 2};
      vecs[4] = '{8'h81, 8'b1000_0001, 34, 2};

      // Reset state, with a write offered that must be ignored.
      RST    = 1'b1;
      bus.WR = 1'b1;
      bus.D  = 8'hAA;
      #1;
      compare_all();
      @(posedge CLK);
      @(negedge CLK);
      compare_all();
      bus.WR = 1'b0;
      RST    = 1'b0;
      idle_steps(2);

      // Single-byte vectors.
      foreach (vecs[i]) begin
         mon_clear();
         step(1'b1, vecs[i].d);
         drain(200);
         check("vec_busy_cycles",  busy_cycles,  vecs[i].exp_busy);
         check("vec_latch_cycles", latch_cycles, vecs[i].exp_latch);
         check("vec_byte_count",   dut_bytes.size(), 1);
         if (dut_bytes.size() > 0) check("vec_bits", dut_bytes[0], vecs[i].exp_bits);
         idle_steps(2);
      end

      // Back-to-back: second byte written 5 cycles after the first.
      mon_clear();
      step(1'b1, 8'h3C);
      idle_steps(4);
      step(1'b1, 8'hC3);
      drain(300);
      check("b2b_busy_cycles", busy_cycles, 68);
      check("b2b_full_cycles", full_cycles, 29);
      check_bytes("b2b", '{8'h3C, 8'hC3});
      idle_steps(2);

      // Overflow: third consecutive write is dropped.
      mon_clear();
      step(1'b1, 8'h01);
      step(1'b1, 8'h02);
      step(1'b1, 8'h03);
      drain(300);
      check("ovf_drops", drop_pulses, 1);
      check_bytes("ovf", '{8'h01, 8'h02});
      idle_steps(2);

      // Write on the final LATCH cycle with nothing held: bypass.
      mon_clear();
      step(1'b1, 8'h11);
      idle_steps(BYTE_CYCLES - 1);
      check("bypass_on_latch", bus.LATCH, 1);
      step(1'b1, 8'h55);
      check("bypass_full", bus.FULL, 0);
      check("bypass_busy", bus.BUSY, 1);
      drain(300);
      check("bypass_busy_cycles", busy_cycles, 68);
      check("bypass_drops", drop_pulses, 0);
      check_bytes("bypass", '{8'h11, 8'h55});
      idle_steps(2);

      // Write on the final LATCH cycle while 0x77 is held.
      mon_clear();
      step(1'b1, 8'h22);
      step(1'b1, 8'h77);
      idle_steps(BYTE_CYCLES - 2);
      check("swap_on_latch", bus.LATCH, 1);
      check("swap_full_before", bus.FULL, 1);
      step(1'b1, 8'h66);
      check("swap_full_after", bus.FULL, 1);
      check("swap_drop", bus.DROP, 0);
      drain(400);
      check("swap_drops", drop_pulses, 0);
      check("swap_busy_cycles", busy_cycles, 102);
      check_bytes("swap", '{8'h22, 8'h77, 8'h66});
      idle_steps(2);

      // Reset at bit 4 of 0xFF with a byte held.
      mon_clear();
      step(1'b1, 8'hFF);
      step(1'b1, 8'h12);
      idle_steps(4 * 2 * DIV - 1);
      check("rst_pre_full", bus.FULL, 1);
      check("rst_pre_sclk", bus.SCLK, 0);
      bus.WR = 1'b0;
      #2;
      RST = 1'b1;
      model_reset();
      #1;
      compare_all();
      bus.WR = 1'b1;
      bus.D  = 8'h5A;
      @(posedge CLK);
      @(negedge CLK);
      compare_all();
      RST = 1'b0;
      mon_clear();
      step(1'b1, 8'h81);
      drain(200);
      check("rst_latch_cycles", latch_cycles, 2);
      check_bytes("rst", '{8'h81});
      idle_steps(2);

      // Randomised traffic against the model.
      mon_clear();
      m_drops_total = 0;
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 11) == 0, 8'($urandom));
      end
      drain(400);
      check("rand_drops", drop_pulses, m_drops_total);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
